// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and constants for the UART receive and transmit paths.
package uart_pkg;
    localparam int   UART_DATA_BITS    = 8;
    localparam logic UART_IDLE_LEVEL   = 1'b1;
    localparam int   UART_CLKS_PER_BIT = 1304;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous line input; resets to the line idle level.
module uart_sync2
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic r_s1, r_s2;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= UART_IDLE_LEVEL;
            r_s2 <= UART_IDLE_LEVEL;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end
    assign o_q = r_s2;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with internal bit timing and one-cycle result strobes.
// Define UART_RX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data_out,
    output logic                      data_valid,
    output logic                      frame_err,
    output logic                      parity_err,
    output logic                      busy
);
    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

    uart_state_t               r_state, w_next;
    logic [CW-1:0]             r_cnt;
    logic [2:0]                r_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_rx_d, r_valid, r_ferr;
    logic                      w_rx_s, w_fall, w_bit_end, w_half_end;
    logic                      w_shift, w_stop, w_cnt_clr, w_valid_set, w_ferr_set, w_par_bad;

    uart_sync2 u_sync (
        .clk(clk),
        .rst(rst),
        .i_d(rx),
        .o_q(w_rx_s)
    );

    assign w_fall     = r_rx_d & ~w_rx_s;
    assign w_bit_end  = r_cnt == LAST;
    assign w_half_end = r_cnt == HALF_M1;

    always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_fall ? START : IDLE;
            START:   w_next = !w_half_end ? START : (w_rx_s ? IDLE : DATA);
`ifdef UART_RX_PARITY_EN
            DATA:    w_next = (w_bit_end && r_idx == 3'd7) ? PARITY : DATA;
            PARITY:  w_next = w_bit_end ? STOP : PARITY;
`else
            DATA:    w_next = (w_bit_end && r_idx == 3'd7) ? STOP : DATA;
`endif
            STOP:    w_next = w_bit_end ? IDLE : STOP;
            default: w_next = IDLE;
        endcase
    end

    // The counter restarts on every state change and at each full bit period.
    always_comb begin
        w_shift     = r_state == DATA && w_bit_end;
        w_stop      = r_state == STOP && w_bit_end;
        w_ferr_set  = w_stop && !w_rx_s;
        w_valid_set = w_stop && w_rx_s && !w_par_bad;
        w_cnt_clr   = r_state == IDLE || w_next != r_state || w_bit_end;
        busy        = r_state != IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_d   <= UART_IDLE_LEVEL;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            data_out <= '0;
            r_valid  <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_rx_d  <= w_rx_s;
            r_cnt   <= w_cnt_clr ? '0 : r_cnt + 1'b1;
            r_idx   <= w_shift ? r_idx + 1'b1 : (r_state == DATA ? r_idx : 3'd0);
            if (w_shift) r_shift <= {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
            if (w_valid_set) data_out <= r_shift;
            r_valid <= w_valid_set;
            r_ferr  <= w_ferr_set;
        end
    end

    assign data_valid = r_valid;
    assign frame_err  = r_ferr;

`ifdef UART_RX_PARITY_EN
    logic r_par, r_perr;
    assign w_par_bad = ^{r_shift, r_par};
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par  <= 1'b0;
            r_perr <= 1'b0;
        end else begin
            if (r_state == PARITY && w_bit_end) r_par <= w_rx_s;
            r_perr <= w_stop && w_rx_s && w_par_bad;
        end
    end
    assign parity_err = r_perr;
`else
    assign w_par_bad  = 1'b0;
    assign parity_err = 1'b0;
`endif
endmodule
